// File: rtl/bubble_page_dump.sv
// bubble_page_dump
//   Collects bubble-memory page bits into an 8192-bit buffer, written one bit
//   at a time. On a boot or user dump request it streams a frame of bytes:
//   a header byte, the page number as two bytes, then the payload bytes read
//   from the buffer (LSB-first bit packing).
//   Optional feature macro: BUBBLE_DUMP_CHECKSUM_EN appends a trailing byte
//   holding the modulo-256 sum of the payload bytes.
module bubble_page_dump #(
  parameter int BOOT_BYTES = 1024,
  parameter int USER_BYTES = 64
) (
  input  logic        MCLK,
  input  logic        nRESET,
  input  logic        nFIFOBUFWRCLKEN,
  input  logic [12:0] FIFOBUFWRADDR,
  input  logic        FIFOBUFWRDATA,
  input  logic        nFIFOSENDBOOT,
  input  logic        nFIFOSENDUSER,
  input  logic [11:0] FIFOCURRPAGE,
  output logic [7:0]  BYTE_DATA,
  output logic        BYTE_VALID,
  input  logic        BYTE_READY,
  output logic        BUSY,
  output logic        OVERRUN
);

  localparam logic [7:0] HDR_BOOT  = 8'hB0;
  localparam logic [7:0] HDR_USER  = 8'h5A;
  localparam logic [9:0] BOOT_LAST = 10'(BOOT_BYTES - 1);
  localparam logic [9:0] USER_LAST = 10'(USER_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PGHI,
    S_PGLO,
    S_FETCH,
    S_DATA,
    S_SUM
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        boot_prev_q, user_prev_q;
  logic [9:0]  idx_q, idx_d;
  logic [11:0] page_q, page_d;
  logic        is_boot_q, is_boot_d;
  logic [7:0]  sum_q, sum_d;

  logic        boot_edge;
  logic        user_edge;
  logic        xfer;
  logic [9:0]  last_idx;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;

  // --------------------------------------------------------------------------
  // Buffer: eight 1024 x 1 lanes, lane i holds bit i of every byte. A bit
  // write only touches its own lane, so single-bit writes need no
  // read-modify-write, while the read port delivers a whole byte at once.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic lane_mem [1024];
      logic rd_bit_q;
      logic lane_we;

      assign lane_we     = !nFIFOBUFWRCLKEN && (FIFOBUFWRADDR[2:0] == 3'(gi));
      assign rd_data[gi] = rd_bit_q;

      // Bit-lane RAM: write port always live, registered read (read-first)
      always_ff @(posedge MCLK) begin
        if (lane_we) begin
          lane_mem[FIFOBUFWRADDR[12:3]] <= FIFOBUFWRDATA;
        end
        if (rd_en) begin
          rd_bit_q <= lane_mem[rd_addr];
        end
      end
    end
  endgenerate

  // Falling edge of a request line against its registered previous level
  assign boot_edge = boot_prev_q && !nFIFOSENDBOOT;
  assign user_edge = user_prev_q && !nFIFOSENDUSER;

  // A byte moves downstream on any edge where it is offered and accepted
  assign xfer     = byte_valid_q && BYTE_READY;
  assign last_idx = is_boot_q ? BOOT_LAST : USER_LAST;

  // The read is launched on the edge entering FETCH, so FETCH sees the byte
  // and copies it into the output register on its way into DATA.
  assign rd_en   = (state_d == S_FETCH);
  assign rd_addr = idx_d;

  // Next-state and next-output computation for the frame sequencer
  always_comb begin
    state_d      = state_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = byte_valid_q;
    idx_d        = idx_q;
    page_d       = page_q;
    is_boot_d    = is_boot_q;
    sum_d        = sum_q;

    // Outside IDLE every request edge is dropped; in IDLE only a user edge
    // coinciding with a boot edge loses.
    if (state_q == S_IDLE) begin
      overrun_d = boot_edge && user_edge;
    end else begin
      overrun_d = boot_edge || user_edge;
    end

    case (state_q)
      S_IDLE: begin
        byte_valid_d = 1'b0;
        if (boot_edge || user_edge) begin
          is_boot_d    = boot_edge;
          page_d       = FIFOCURRPAGE;
          byte_data_d  = boot_edge ? HDR_BOOT : HDR_USER;
          byte_valid_d = 1'b1;
          idx_d        = 10'd0;
          sum_d        = 8'd0;
          state_d      = S_HDR;
        end
      end
      S_HDR: begin
        if (xfer) begin
          byte_data_d = {4'h0, page_q[11:8]};
          state_d     = S_PGHI;
        end
      end
      S_PGHI: begin
        if (xfer) begin
          byte_data_d = page_q[7:0];
          state_d     = S_PGLO;
        end
      end
      S_PGLO: begin
        if (xfer) begin
          byte_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      S_FETCH: begin
        byte_data_d  = rd_data;
        byte_valid_d = 1'b1;
        state_d      = S_DATA;
      end
      S_DATA: begin
        if (xfer) begin
          sum_d = sum_q + byte_data_q;
          if (idx_q == last_idx) begin
`ifdef BUBBLE_DUMP_CHECKSUM_EN
            byte_data_d  = sum_q + byte_data_q;
            byte_valid_d = 1'b1;
            state_d      = S_SUM;
`else
            byte_valid_d = 1'b0;
            state_d      = S_IDLE;
`endif
          end else begin
            idx_d        = idx_q + 10'd1;
            byte_valid_d = 1'b0;
            state_d      = S_FETCH;
          end
        end
      end
      S_SUM: begin
        if (xfer) begin
          byte_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        byte_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Frame sequencer state and registered outputs
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= S_IDLE;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      boot_prev_q  <= 1'b1;
      user_prev_q  <= 1'b1;
      idx_q        <= 10'd0;
      page_q       <= 12'h000;
      is_boot_q    <= 1'b0;
      sum_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      boot_prev_q  <= nFIFOSENDBOOT;
      user_prev_q  <= nFIFOSENDUSER;
      idx_q        <= idx_d;
      page_q       <= page_d;
      is_boot_q    <= is_boot_d;
      sum_q        <= sum_d;
    end
  end

  assign BYTE_DATA  = byte_data_q;
  assign BYTE_VALID = byte_valid_q;
  assign BUSY       = busy_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_bubble_page_dump.sv
// tb_bubble_page_dump
//   Self-checking bench for bubble_page_dump (default parameters).
//   Expected frame bytes come from a byte model of the buffer and are queued
//   when a request is driven; a negedge monitor pops and compares each byte
//   the DUT hands over. Build with +define+BUBBLE_DUMP_CHECKSUM_EN to also
//   expect and test the trailing sum byte.
`timescale 1ns/1ps
module tb_bubble_page_dump;

  localparam int BOOT_N = 1024;
  localparam int USER_N = 64;

  logic        MCLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        nFIFOBUFWRCLKEN = 1'b1;
  logic [12:0] FIFOBUFWRADDR = 13'd0;
  logic        FIFOBUFWRDATA = 1'b0;
  logic        nFIFOSENDBOOT = 1'b1;
  logic        nFIFOSENDUSER = 1'b1;
  logic [11:0] FIFOCURRPAGE = 12'h000;
  logic [7:0]  BYTE_DATA;
  logic        BYTE_VALID;
  logic        BYTE_READY = 1'b0;
  logic        BUSY;
  logic        OVERRUN;

  bubble_page_dump #(
    .BOOT_BYTES(BOOT_N),
    .USER_BYTES(USER_N)
  ) dut (
    .MCLK            (MCLK),
    .nRESET          (nRESET),
    .nFIFOBUFWRCLKEN (nFIFOBUFWRCLKEN),
    .FIFOBUFWRADDR   (FIFOBUFWRADDR),
    .FIFOBUFWRDATA   (FIFOBUFWRDATA),
    .nFIFOSENDBOOT   (nFIFOSENDBOOT),
    .nFIFOSENDUSER   (nFIFOSENDUSER),
    .FIFOCURRPAGE    (FIFOCURRPAGE),
    .BYTE_DATA       (BYTE_DATA),
    .BYTE_VALID      (BYTE_VALID),
    .BYTE_READY      (BYTE_READY),
    .BUSY            (BUSY),
    .OVERRUN         (OVERRUN)
  );

  always #10 MCLK = ~MCLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_mem [1024];
  logic [7:0] exp_q [$];

  int xfer_cnt   = 0;
  int ovr_cnt    = 0;
  int ready_mode = 0;   // 0 always ready, 1 toggle every 3 cycles, 2 random, 3 never
  int rdy_cnt    = 0;

  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  typedef struct {
    logic        boot;
    logic [11:0] page;
    int          rmode;
    logic [7:0]  hdr;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream ready pattern, driven just after each rising edge
  always @(posedge MCLK) begin
    #1;
    case (ready_mode)
      0: BYTE_READY = 1'b1;
      1: begin
        rdy_cnt++;
        if (rdy_cnt >= 3) begin
          rdy_cnt    = 0;
          BYTE_READY = !BYTE_READY;
        end
      end
      2: BYTE_READY = 1'($urandom_range(0, 1));
      default: BYTE_READY = 1'b0;
    endcase
  end

  // Monitor: sampled mid-cycle, a valid+ready pair means the byte moves on the next edge
  always @(negedge MCLK) begin
    if (nRESET) begin
      if (OVERRUN) ovr_cnt++;
      if (stall_prev) begin
        check("stall_valid_held", BYTE_VALID, 1'b1);
        check("stall_data_stable", BYTE_DATA, stall_data);
      end
      if (BYTE_VALID && BYTE_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_byte: got 0x%02h, expected no byte", BYTE_DATA);
        end else begin
          check($sformatf("frame_byte_%0d", xfer_cnt), BYTE_DATA, exp_q.pop_front());
        end
        xfer_cnt++;
      end
      stall_prev = BYTE_VALID && !BYTE_READY;
      stall_data = BYTE_DATA;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge MCLK);
    #2;
  endtask

  task automatic write_bit(input int addr, input logic v);
    nFIFOBUFWRCLKEN = 1'b0;
    FIFOBUFWRADDR   = 13'(addr);
    FIFOBUFWRDATA   = v;
    model_mem[addr >> 3][addr & 7] = v;
    tick();
    nFIFOBUFWRCLKEN = 1'b1;
  endtask

  task automatic write_byte(input int k, input logic [7:0] val);
    for (int i = 0; i < 8; i++) write_bit(8 * k + i, val[i]);
  endtask

  task automatic push_frame(input logic [7:0] hdr, input logic [7:0] hi,
                            input logic [7:0] lo, input int n);
    logic [7:0] sum;
    sum = 8'h00;
    exp_q.push_back(hdr);
    exp_q.push_back(hi);
    exp_q.push_back(lo);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_mem[k]);
      sum = sum + model_mem[k];
    end
`ifdef BUBBLE_DUMP_CHECKSUM_EN
    exp_q.push_back(sum);
`endif
  endtask

  task automatic request(input logic boot, input logic user, input logic [11:0] page);
    FIFOCURRPAGE  = page;
    nFIFOSENDBOOT = !boot;
    nFIFOSENDUSER = !user;
    tick();
    check("busy_after_request", BUSY, 1'b1);
    tick();
    nFIFOSENDBOOT = 1'b1;
    nFIFOSENDUSER = 1'b1;
  endtask

  task automatic wait_done(input string name, input int bound);
    int c;
    c = 0;
    while ((BUSY || exp_q.size() != 0) && c < bound) begin
      tick();
      c++;
    end
    check({name, "_busy_end"}, BUSY, 1'b0);
    check({name, "_bytes_left"}, exp_q.size(), 0);
    check({name, "_valid_end"}, BYTE_VALID, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    int x0;
    int o0;
    int c;

    vecs[0] = '{1'b0, 12'h123, 0, 8'h5A, 8'h01, 8'h23};
    vecs[1] = '{1'b0, 12'hFFF, 2, 8'h5A, 8'h0F, 8'hFF};
    vecs[2] = '{1'b1, 12'hA5C, 1, 8'hB0, 8'h0A, 8'h5C};
    vecs[3] = '{1'b0, 12'h000, 1, 8'h5A, 8'h00, 8'h00};

    // Reset values while held in reset
    repeat (3) tick();
    check("reset_valid", BYTE_VALID, 1'b0);
    check("reset_busy", BUSY, 1'b0);
    check("reset_overrun", OVERRUN, 1'b0);
    check("reset_data", BYTE_DATA, 8'h00);
    nRESET = 1'b1;
    tick();

    // Fill the whole buffer, then force byte 0 to bits 1,0,1,1,0,0,0,0
    for (int a = 0; a < 8192; a++) write_bit(a, 1'($urandom_range(0, 1)));
    write_bit(0, 1'b1); write_bit(1, 1'b0); write_bit(2, 1'b1); write_bit(3, 1'b1);
    write_bit(4, 1'b0); write_bit(5, 1'b0); write_bit(6, 1'b0); write_bit(7, 1'b0);
    check("first_user_payload_model", model_mem[0], 8'h0D);

    // Table-driven dumps, each new request issued in the first idle cycle
    for (int v = 0; v < 4; v++) begin
      ready_mode = vecs[v].rmode;
      push_frame(vecs[v].hdr, vecs[v].hi, vecs[v].lo, vecs[v].boot ? BOOT_N : USER_N);
      x0 = xfer_cnt;
      request(vecs[v].boot, !vecs[v].boot, vecs[v].page);
      wait_done($sformatf("vec%0d", v), 20000);
      $display("frame vec%0d hdr=%02h page=%03h bytes=%0d", v, vecs[v].hdr,
               vecs[v].page, xfer_cnt - x0);
    end

    // Simultaneous requests: boot wins, one overrun; extra user edge mid-frame
    ready_mode = 0;
    o0 = ovr_cnt;
    push_frame(8'hB0, 8'h03, 8'h21, BOOT_N);
    request(1'b1, 1'b1, 12'h321);
    tick();
    check("overrun_same_cycle", ovr_cnt - o0, 1);
    repeat (20) tick();
    nFIFOSENDUSER = 1'b0;
    repeat (2) tick();
    nFIFOSENDUSER = 1'b1;
    repeat (2) tick();
    check("overrun_mid_frame", ovr_cnt - o0, 2);
    wait_done("both_edges", 20000);
    check("overrun_total", ovr_cnt - o0, 2);
    $display("frame both_edges hdr=b0 page=321 overruns=%0d", ovr_cnt - o0);

    // Buffer writes during a stalled header land in the same frame's payload
    ready_mode = 3;
    tick();
    request(1'b0, 1'b1, 12'h0AB);
    write_byte(40, ~model_mem[40]);
    write_byte(5, 8'h96);
    push_frame(8'h5A, 8'h00, 8'hAB, USER_N);
    ready_mode = 0;
    wait_done("write_in_frame", 5000);
    $display("frame write_in_frame hdr=5a page=0ab byte40=%02h", model_mem[40]);

    // Reset while payload byte 10 is on offer
    ready_mode = 0;
    push_frame(8'h5A, 8'h01, 8'h11, USER_N);
    x0 = xfer_cnt;
    request(1'b0, 1'b1, 12'h111);
    c = 0;
    while ((xfer_cnt - x0) < 13 && c < 400) begin
      tick();
      c++;
    end
    check("reached_byte10", xfer_cnt - x0, 13);
    ready_mode = 3;
    repeat (2) tick();
    check("byte10_offered", BYTE_VALID, 1'b1);
    check("byte10_value", BYTE_DATA, model_mem[10]);
    nRESET = 1'b0;
    #1;
    check("abort_valid", BYTE_VALID, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    check("abort_data", BYTE_DATA, 8'h00);
    exp_q.delete();
    repeat (2) tick();
    nRESET = 1'b1;
    ready_mode = 0;
    repeat (3) tick();
    check("no_bytes_after_abort", xfer_cnt - x0, 13);
    check("idle_after_abort", BUSY, 1'b0);
    $display("frame aborted after %0d bytes", xfer_cnt - x0);
    push_frame(8'h5A, 8'h01, 8'h11, USER_N);
    request(1'b0, 1'b1, 12'h111);
    wait_done("after_abort", 5000);
    $display("frame after_abort hdr=5a page=111");

`ifdef BUBBLE_DUMP_CHECKSUM_EN
    // Trailing sum byte: 64 x 0x04 wraps to 0x00, 64 x 0x03 gives 0xC0
    for (int k = 0; k < USER_N; k++) write_byte(k, 8'h04);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00); exp_q.push_back(8'h42);
    for (int k = 0; k < USER_N; k++) exp_q.push_back(8'h04);
    exp_q.push_back(8'h00);
    request(1'b0, 1'b1, 12'h042);
    wait_done("sum_04", 5000);
    $display("frame sum_04 trailing=00");
    for (int k = 0; k < USER_N; k++) write_byte(k, 8'h03);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h00); exp_q.push_back(8'h43);
    for (int k = 0; k < USER_N; k++) exp_q.push_back(8'h03);
    exp_q.push_back(8'hC0);
    request(1'b0, 1'b1, 12'h043);
    wait_done("sum_03", 5000);
    $display("frame sum_03 trailing=c0");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case anything above stops making progress
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
